// File: rtl/riscv_lsu_pkg.sv
// Shared RV32I load/store definitions: access widths, funct3 codes, LSU states
// and the alignment/legality rules used by the load/store unit.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  function automatic mem_width_t f3_width(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  // Rejects misaligned halfwords/words and funct3 codes that have no access.
  function automatic logic lsu_legal(input logic       write,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (write) begin
      case (funct3)
        FUNCT3_SB: ok = 1'b1;
        FUNCT3_SH: ok = ~addr_lo[0];
        FUNCT3_SW: ok = (addr_lo == 2'b00);
        default:   ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LBU: ok = 1'b1;
        FUNCT3_LH, FUNCT3_LHU: ok = ~addr_lo[0];
        FUNCT3_LW:             ok = (addr_lo == 2'b00);
        default:               ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane logic shared by both paths: store byte enables and lane replication,
// load lane selection with sign/zero extension.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  assign lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign sext   = ~funct3_i[2];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    case (f3_width(funct3_i))
      BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sext & lane_b[7]}}, lane_b};
      end
      HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sext & lane_h[15]}}, lane_h};
      end
      default: begin
        be_o    = '1;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time, traps illegal accesses locally and
// runs a req/gnt/rvalid data-memory protocol with registered outputs.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGA = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [REGA-1:0]   req_rd,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [REGA-1:0]   resp_rd,
  output logic              resp_fault,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  lsu_state_t      state_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      funct3_q;
  logic            write_q;
  logic [REGA-1:0] rd_q;

  logic [2:0]        sel_funct3_d;
  logic [1:0]        sel_addr_lo_d;
  logic [XLEN/8-1:0] be_d;
  logic [XLEN-1:0]   wdata_d;
  logic [XLEN-1:0]   rdata_d;

  assign req_ready = (state_q == IDLE);

  // Live request fields drive the aligner at acceptance; latched ones at read return.
  assign sel_funct3_d  = (state_q == IDLE) ? req_funct3    : funct3_q;
  assign sel_addr_lo_d = (state_q == IDLE) ? req_addr[1:0] : addr_lo_q;

  riscv_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i  (sel_funct3_d),
    .addr_lo_i (sel_addr_lo_d),
    .wdata_i   (req_wdata),
    .rdata_i   (dmem_rdata),
    .be_o      (be_d),
    .wdata_o   (wdata_d),
    .rdata_o   (rdata_d)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_lo_q  <= '0;
      funct3_q   <= '0;
      write_q    <= 1'b0;
      rd_q       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= '0;
      resp_fault <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_lo_q <= req_addr[1:0];
            funct3_q  <= req_funct3;
            write_q   <= req_write;
            rd_q      <= req_rd;
            if (!lsu_legal(req_write, req_funct3, req_addr[1:0])) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
              resp_rd    <= '0;
            end else begin
              state_q    <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= req_write;
              dmem_be    <= req_write ? be_d : '1;
              dmem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              dmem_wdata <= req_write ? wdata_d : '0;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (write_q) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_rdata <= '0;
              resp_rd    <= '0;
            end else begin
              state_q <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= rdata_d;
            resp_rd    <= rd_q;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
          resp_rd    <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: expected responses are queued at request time
// and compared by a monitor whenever resp_valid is seen.
module tb_riscv_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  riscv_lsu #(.XLEN(32), .REGA(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rd      (req_rd),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_rd     (resp_rd),
    .resp_fault  (resp_fault),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", {31'b0, resp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_rd", {27'b0, resp_rd}, {27'b0, e.rd});
        check("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
      end
    end
  end

  task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] mem_word,
                           input logic fault, input logic [31:0] exp_data,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int   lat;
    int   guard;
    int   exp_lat;
    exp_t e;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    e.rdata = (wr || fault) ? 32'd0 : exp_data;
    e.rd    = (wr || fault) ? 5'd0 : rd;
    e.fault = fault;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1;
    if (fault) begin
      check("fault_no_dmem_req", {31'b0, dmem_req}, 32'd0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check("dmem_req", {31'b0, dmem_req}, 32'd1);
        check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        check("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
        check("dmem_we", {31'b0, dmem_we}, {31'b0, wr});
        if (wr) check("dmem_wdata", dmem_wdata, exp_wd);
        check("ready_busy", {31'b0, req_ready}, 32'd0);
        dmem_gnt = (i == gnt_dly);
        @(posedge clk); #1;
        lat++;
      end
      dmem_gnt = 1'b0;
      check("dmem_req_drop", {31'b0, dmem_req}, 32'd0);
      if (!wr) begin
        for (int i = 1; i < rv_dly; i++) begin
          @(posedge clk); #1;
          lat++;
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = mem_word;
        @(posedge clk); #1;
        lat++;
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
      end
    end
    guard = 0;
    while (!resp_valid && guard < 50) begin
      @(posedge clk); #1;
      lat++;
      guard++;
    end
    exp_lat = fault ? 1 : (wr ? 2 + gnt_dly : 2 + gnt_dly + rv_dly);
    check("latency", lat, exp_lat);
    check("ready_in_resp", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
    check("ready_after_resp", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_funct3  = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_rd      = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_dmem_be", {28'b0, dmem_be}, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    // Stores
    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd7, 0, 1, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF);
    do_access(1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd2, 0, 1, 32'h0, 1'b0, 32'h0, 4'b1000, 32'hA5A5A5A5);
    do_access(1'b1, 3'b000, 32'h201, 32'h1234565A, 5'd2, 1, 1, 32'h0, 1'b0, 32'h0, 4'b0010, 32'h5A5A5A5A);
    do_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd4, 0, 1, 32'h0, 1'b0, 32'h0, 4'b1100, 32'hABCDABCD);
    do_access(1'b1, 3'b001, 32'h100, 32'h00008765, 5'd4, 0, 1, 32'h0, 1'b0, 32'h0, 4'b0011, 32'h87658765);

    // Loads with lane select and extension
    do_access(1'b0, 3'b000, 32'h302, 32'h0, 5'd3, 0, 1, 32'h12807F34, 1'b0, 32'hFFFFFF80, 4'b1111, 32'h0);
    do_access(1'b0, 3'b100, 32'h302, 32'h0, 5'd3, 0, 1, 32'h12807F34, 1'b0, 32'h00000080, 4'b1111, 32'h0);
    do_access(1'b0, 3'b101, 32'h302, 32'h0, 5'd5, 0, 1, 32'h12807F34, 1'b0, 32'h00001280, 4'b1111, 32'h0);
    do_access(1'b0, 3'b000, 32'h301, 32'h0, 5'd6, 0, 1, 32'h12807F34, 1'b0, 32'h0000007F, 4'b1111, 32'h0);
    do_access(1'b0, 3'b001, 32'h300, 32'h0, 5'd8, 0, 1, 32'h00008001, 1'b0, 32'hFFFF8001, 4'b1111, 32'h0);
    do_access(1'b0, 3'b001, 32'h302, 32'h0, 5'd8, 0, 1, 32'hC0010000, 1'b0, 32'hFFFFC001, 4'b1111, 32'h0);
    do_access(1'b0, 3'b010, 32'h304, 32'h0, 5'd31, 0, 1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0);

    // Faults: misaligned and illegal funct3
    do_access(1'b0, 3'b010, 32'h105, 32'h0, 5'd9, 0, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
    do_access(1'b0, 3'b011, 32'h000, 32'h0, 5'd9, 0, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
    do_access(1'b0, 3'b101, 32'h003, 32'h0, 5'd9, 0, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
    do_access(1'b1, 3'b001, 32'h101, 32'h0, 5'd9, 0, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
    do_access(1'b1, 3'b011, 32'h100, 32'h0, 5'd9, 0, 1, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);

    // Memory wait states: gnt 3 cycles late, rvalid 2 cycles after gnt
    do_access(1'b0, 3'b010, 32'h400, 32'h0, 5'd17, 3, 2, 32'h89ABCDEF, 1'b0, 32'h89ABCDEF, 4'b1111, 32'h0);

    // Reset while waiting for read data abandons the load
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_rd     = 5'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    dmem_gnt  = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55555555;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("late_rvalid_no_resp", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("late_rvalid_no_resp2", {31'b0, resp_valid}, 32'd0);

    do_access(1'b0, 3'b100, 32'h503, 32'h0, 5'd12, 0, 1, 32'hF1223344, 1'b0, 32'h000000F1, 4'b1111, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_leftover", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit between the hart's memory-access stage and the data memory port. Accepts one load or store request at a time over a valid/ready handshake. Produces byte enables and lane-replicated write data, and runs a grant/rvalid data-memory protocol. Returns sign- or zero-extended load data, tagged with the destination register, to write-back. Misaligned or illegal-width accesses are trapped locally and never reach memory.

Parameters:
XLEN, 32, datapath and address width; only 32 is supported (byte enables are XLEN/8 = 4).
REGA, 5, register-index width for rd tags.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  MA stage presents a request
req_ready  out  1  LSU can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width code (LB/LH/LW/LBU/LHU; SB/SH/SW)
req_addr  in  XLEN  effective byte address
req_wdata  in  XLEN  store data (rs2), low-aligned
req_rd  in  REGA  load destination register
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and faults
resp_rd  out  REGA  destination; 0 for stores and faults
resp_fault  out  1  misaligned or illegal funct3; qualified by resp_valid
dmem_req  out  1  memory request
dmem_we  out  1  write enable
dmem_be  out  XLEN/8  byte enables
dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
dmem_wdata  out  XLEN  lane-replicated store data
dmem_gnt  in  1  memory accepted request this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  XLEN  read word

Behaviour:
- The block uses one clock (clk). Reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - FSM goes to IDLE.
  - All registered outputs are 0: resp_*, dmem_*.
  - req_ready is combinational (state == IDLE), so it is 1 in the first cycle after reset.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - On req_valid & req_ready, latch addr, funct3, write, wdata and rd.
  - Legality check:
    - Halfword requires addr[0] = 0.
    - Word requires addr[1:0] = 0.
    - Loads with funct3 011/110/111 are illegal.
    - Stores with funct3 > 010 are illegal.
  - Illegal request: go to RESP with fault = 1; dmem_req is never asserted.
  - Legal request: go to REQ.
- REQ:
  - dmem_req = 1. dmem_we, dmem_be, dmem_addr and dmem_wdata are held stable until dmem_gnt.
  - On gnt, a store goes to RESP and a load goes to WAIT_R.
  - dmem_req deasserts on the edge after gnt.
- WAIT_R:
  - dmem_rvalid is sampled only in this state. Memory guarantees rvalid no earlier than the cycle after gnt.
  - On rvalid, capture the lane selected by addr[1:0]:
    - byte: rdata[8*a+7:8*a]
    - half: addr[1] selects the upper or lower half
  - Extend the captured lane: LB/LH sign-extend, LBU/LHU zero-extend. Then go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then go to IDLE.
  - A new request is accepted no earlier than the following cycle.
- Store encoding:
  - SB: wdata = {4{wdata[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{wdata[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata unchanged, be = 4'b1111.
- Reads drive be = 4'b1111 and we = 0.
- Latency, request acceptance to resp_valid, with zero-wait memory:
  - store: 2 cycles
  - load: 3 cycles
  - fault: 1 cycle
- Each memory wait cycle adds one cycle.
- req_valid while not ready is ignored. The producer holds its request until accepted.
- Reset mid-transaction abandons the access:
  - dmem_req drops at the reset edge.
  - No resp_valid is produced.
  - A late dmem_rvalid after reset is ignored in IDLE.
- gnt outside REQ is ignored.

Decomposition:
- The shared riscv isa package gains:
  - mem_width_t (BYTE/HALF/WORD)
  - load/store funct3 constants: FUNCT3_LB, LH, LW, LBU, LHU, SB, SH, SW
  - lsu_state_t enum
- One natural sub-module, riscv_lsu_align: combinational lane select, extension, byte-enable and write-data replication. It is shared by the load and store paths.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, gnt same cycle -> dmem_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1; resp_valid 2 cycles after accept, resp_rd 0, fault 0.
- SB addr 0x203, wdata 0x000000A5 -> dmem_addr 0x200, be 1000, wdata 0xA5A5A5A5.
- LB addr 0x302, rdata 0x12807F34 -> resp_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x302 -> 0x00001280.
- LW addr 0x105 -> resp_valid + resp_fault the next cycle; dmem_req stays 0; resp_rdata 0.
- LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> dmem_* stable throughout REQ; req_ready 0 until after the resp_valid cycle; correct rd tag returned.
- rst asserted in WAIT_R, then rvalid pulses -> no resp_valid; req_ready 1 the cycle after reset; the next request completes normally.
